// File: rtl/vga_osd_pkg.sv
// -----------------------------------------------------------------------------
// vga_osd_pkg
// Shared definitions for the OSD framebuffer with colour look-up table:
//   - fill_state_e : fill-engine FSM states
//   - PAL_*_BIT    : reset-palette bit patterns (entry 0 black, others white)
//   - clog2()      : address-width helper for the pixel RAM
// -----------------------------------------------------------------------------
package vga_osd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Reset palette: entry 0 is all-zero, every other entry is all-ones, which
    // with BPP=1 reproduces the old fixed two-colour OSD.
    localparam logic PAL_ENTRY0_BIT = 1'b0;
    localparam logic PAL_OTHER_BIT  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_osd_fb_clut_if.sv
// -----------------------------------------------------------------------------
// vga_osd_fb_clut_if
// Bundles every non-clock/reset signal of the OSD framebuffer.
//   VGA side  : iVGA_ADDR, iVGA_VALID -> oRed/oGreen/oBlue, oVALID, oTRANSP
//   Host side : iWR_VALID/oWR_READY, iWR_ADDR, iWR_DATA
//   Palette   : iPAL_WE, iPAL_IDX, iPAL_RGB ({R,G,B})
//   Fill      : iFILL_START, iFILL_DATA -> oFILL_BUSY
//   Colour key: iTRANSP_EN
// master = host/VGA controller side, slave = the framebuffer.
// -----------------------------------------------------------------------------
interface vga_osd_fb_clut_if #(
    parameter int BPP     = 1,
    parameter int AW      = 19,
    parameter int COLOR_W = 10
);
    logic [AW-1:0]        iVGA_ADDR;
    logic                 iVGA_VALID;
    logic [COLOR_W-1:0]   oRed;
    logic [COLOR_W-1:0]   oGreen;
    logic [COLOR_W-1:0]   oBlue;
    logic                 oVALID;
    logic                 oTRANSP;
    logic                 iTRANSP_EN;
    logic                 iWR_VALID;
    logic                 oWR_READY;
    logic [AW-1:0]        iWR_ADDR;
    logic [BPP-1:0]       iWR_DATA;
    logic                 iPAL_WE;
    logic [BPP-1:0]       iPAL_IDX;
    logic [3*COLOR_W-1:0] iPAL_RGB;
    logic                 iFILL_START;
    logic [BPP-1:0]       iFILL_DATA;
    logic                 oFILL_BUSY;

    modport master (
        output iVGA_ADDR, iVGA_VALID, iTRANSP_EN, iWR_VALID, iWR_ADDR, iWR_DATA,
               iPAL_WE, iPAL_IDX, iPAL_RGB, iFILL_START, iFILL_DATA,
        input  oRed, oGreen, oBlue, oVALID, oTRANSP, oWR_READY, oFILL_BUSY
    );

    modport slave (
        input  iVGA_ADDR, iVGA_VALID, iTRANSP_EN, iWR_VALID, iWR_ADDR, iWR_DATA,
               iPAL_WE, iPAL_IDX, iPAL_RGB, iFILL_START, iFILL_DATA,
        output oRed, oGreen, oBlue, oVALID, oTRANSP, oWR_READY, oFILL_BUSY
    );
endinterface

// File: rtl/vga_osd_dpram.sv
// -----------------------------------------------------------------------------
// vga_osd_dpram
// Simple dual-port pixel RAM, DEPTH x BPP, single clock.
//   clk_i           : clock
//   we_i/waddr_i/wdata_i : write port
//   raddr_i         : read address, sampled every cycle
//   rdata_o         : registered read data (old data on read-during-write)
// -----------------------------------------------------------------------------
module vga_osd_dpram #(
    parameter int BPP   = 1,
    parameter int DEPTH = 307200,
    parameter int AW    = 19
) (
    input  logic           clk_i,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  logic [BPP-1:0] wdata_i,
    input  logic [AW-1:0]  raddr_i,
    output logic [BPP-1:0] rdata_o
);

    logic [BPP-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; its contents
    // are undefined until written, and the read register is plain data too.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        // NOTE: non-blocking assignments make this read see the pre-write
        // contents, which is exactly the old-data read-during-write behaviour.
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/vga_osd_fb_clut.sv
// -----------------------------------------------------------------------------
// vga_osd_fb_clut
// On-screen-display framebuffer: BPP-bit palette index per pixel, run-time
// writable 2**BPP-entry colour look-up table, full-screen fill engine and an
// optional colour key on index 0.
//   iCLK, iRST_N : pixel clock, asynchronous active-low reset
//   bus          : vga_osd_fb_clut_if.slave (VGA read, host write, palette,
//                  fill and colour-key signals)
// Read pipe: address registered into the RAM, index out one cycle later,
// palette lookup registered into the colour outputs the cycle after that.
// -----------------------------------------------------------------------------
module vga_osd_fb_clut
    import vga_osd_pkg::*;
#(
    parameter int BPP     = 1,
    parameter int DEPTH   = 307200,
    parameter int AW      = 19,
    parameter int COLOR_W = 10
) (
    input  logic iCLK,
    input  logic iRST_N,
    vga_osd_fb_clut_if.slave bus
);

    localparam int RAM_AW_RAW = clog2(DEPTH);
    localparam int RAM_AW     = (RAM_AW_RAW > 0) ? RAM_AW_RAW : 1;
    localparam int NPAL       = 1 << BPP;
    localparam int RGB_W      = 3 * COLOR_W;

    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Fill FSM and write-port arbitration
    // ------------------------------------------------------------------
    fill_state_e    state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [BPP-1:0] fill_idx_q, fill_idx_d;

    logic              wr_in_range;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [BPP-1:0]    ram_wdata;

    assign wr_in_range = ({1'b0, bus.iWR_ADDR} < DEPTH_X);

    // Host writes and the fill engine never compete: the host is only
    // accepted in IDLE and the fill engine only writes in FILL.
    // NOTE: every signal gets its default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_idx_d = fill_idx_q;
        ram_we     = 1'b0;
        ram_waddr  = bus.iWR_ADDR[RAM_AW-1:0];
        ram_wdata  = bus.iWR_DATA;
        case (state_q)
            IDLE: begin
                // Out-of-range host writes are acknowledged but dropped.
                ram_we = bus.iWR_VALID && wr_in_range;
                if (bus.iFILL_START) begin
                    state_d    = FILL;
                    cnt_d      = '0;
                    fill_idx_d = bus.iFILL_DATA;
                end
            end
            FILL: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q[RAM_AW-1:0];
                ram_wdata = fill_idx_q;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            fill_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_idx_q <= fill_idx_d;
        end
    end

    assign bus.oWR_READY  = (state_q == IDLE);
    assign bus.oFILL_BUSY = (state_q == FILL);

    // ------------------------------------------------------------------
    // Pixel RAM
    // ------------------------------------------------------------------
    logic              rd_in_range;
    logic [RAM_AW-1:0] ram_raddr;
    logic [BPP-1:0]    ram_rdata;

    assign rd_in_range = ({1'b0, bus.iVGA_ADDR} < DEPTH_X);
    // Clamp so the RAM is never addressed past its end; the index is
    // masked to 0 later for out-of-range pixels anyway.
    assign ram_raddr   = rd_in_range ? bus.iVGA_ADDR[RAM_AW-1:0] : '0;

    vga_osd_dpram #(
        .BPP   (BPP),
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_dpram (
        .clk_i   (iCLK),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read pipe stage 1: qualifiers travelling alongside the RAM read
    // ------------------------------------------------------------------
    logic rd_valid_q;
    logic rd_in_range_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rd_valid_q    <= 1'b0;
            rd_in_range_q <= 1'b0;
        end else begin
            rd_valid_q    <= bus.iVGA_VALID;
            rd_in_range_q <= rd_in_range;
        end
    end

    logic [BPP-1:0] pix_idx;
    assign pix_idx = rd_in_range_q ? ram_rdata : '0;

    // ------------------------------------------------------------------
    // Palette: small register array, reset to the legacy two-colour map.
    // A write lands at the clock edge, so a lookup at that same edge still
    // reads the previous entry.
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] pal_q [NPAL];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NPAL; i++) begin
                pal_q[i] <= (i == 0) ? {RGB_W{PAL_ENTRY0_BIT}} : {RGB_W{PAL_OTHER_BIT}};
            end
        end else if (bus.iPAL_WE) begin
            pal_q[bus.iPAL_IDX] <= bus.iPAL_RGB;
        end
    end

    // ------------------------------------------------------------------
    // Read pipe stage 2: registered colour outputs
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] rgb_q;
    logic             valid_q;
    logic             transp_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rgb_q    <= '0;
            valid_q  <= 1'b0;
            transp_q <= 1'b0;
        end else if (rd_valid_q) begin
            rgb_q    <= pal_q[pix_idx];
            valid_q  <= 1'b1;
            transp_q <= (pix_idx == '0) && bus.iTRANSP_EN;
        end else begin
            rgb_q    <= '0;
            valid_q  <= 1'b0;
            transp_q <= 1'b0;
        end
    end

    assign bus.oRed    = rgb_q[RGB_W-1 -: COLOR_W];
    assign bus.oGreen  = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.oBlue   = rgb_q[COLOR_W-1:0];
    assign bus.oVALID  = valid_q;
    assign bus.oTRANSP = transp_q;

endmodule

// File: tb/tb_vga_osd_fb_clut.sv
// -----------------------------------------------------------------------------
// tb_vga_osd_fb_clut
// Two instances share clock and reset: u_dut1 (BPP=1) checks the legacy
// two-colour behaviour, u_dut2 (BPP=2) covers palette, fill, colour key,
// out-of-range addresses, randomized traffic and reset during fill.
// Expected values come from a behavioural model: an array of pixel indices
// and an array of palette colours updated in program order.
// -----------------------------------------------------------------------------
module tb_vga_osd_fb_clut;

    localparam int DEPTH = 64;
    localparam int AW    = 7;
    localparam int CW    = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_osd_fb_clut_if #(.BPP(1), .AW(AW), .COLOR_W(CW)) if1 ();
    vga_osd_fb_clut_if #(.BPP(2), .AW(AW), .COLOR_W(CW)) if2 ();

    vga_osd_fb_clut #(.BPP(1), .DEPTH(DEPTH), .AW(AW), .COLOR_W(CW)) u_dut1 (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (if1)
    );

    vga_osd_fb_clut #(.BPP(2), .DEPTH(DEPTH), .AW(AW), .COLOR_W(CW)) u_dut2 (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (if2)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model of u_dut2
    int          mem_m [DEPTH];
    logic [29:0] pal_m [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [29:0] default_pal(input int i);
        return (i == 0) ? 30'h0 : 30'h3FFF_FFFF;
    endfunction

    function automatic void reset_pal_model();
        for (int i = 0; i < 4; i++) pal_m[i] = default_pal(i);
    endfunction

    // Expected {oVALID, oTRANSP, R, G, B} for a valid read of addr
    function automatic logic [31:0] exp_read(input int addr, input bit tr_en);
        int idx;
        idx = (addr < DEPTH) ? mem_m[addr] : 0;
        return {1'b1, tr_en && (idx == 0), pal_m[idx]};
    endfunction

    function automatic logic [31:0] obs1();
        return {if1.oVALID, if1.oTRANSP, if1.oRed, if1.oGreen, if1.oBlue};
    endfunction

    function automatic logic [31:0] obs2();
        return {if2.oVALID, if2.oTRANSP, if2.oRed, if2.oGreen, if2.oBlue};
    endfunction

    task automatic idle_inputs();
        if1.iVGA_ADDR = '0; if1.iVGA_VALID = 0; if1.iTRANSP_EN = 0;
        if1.iWR_VALID = 0;  if1.iWR_ADDR = '0;  if1.iWR_DATA = '0;
        if1.iPAL_WE = 0;    if1.iPAL_IDX = '0;  if1.iPAL_RGB = '0;
        if1.iFILL_START = 0; if1.iFILL_DATA = '0;
        if2.iVGA_ADDR = '0; if2.iVGA_VALID = 0; if2.iTRANSP_EN = 0;
        if2.iWR_VALID = 0;  if2.iWR_ADDR = '0;  if2.iWR_DATA = '0;
        if2.iPAL_WE = 0;    if2.iPAL_IDX = '0;  if2.iPAL_RGB = '0;
        if2.iFILL_START = 0; if2.iFILL_DATA = '0;
    endtask

    task automatic rd1(input int addr, output logic [31:0] o);
        if1.iVGA_VALID = 1; if1.iVGA_ADDR = AW'(addr);
        tick();
        if1.iVGA_VALID = 0;
        tick();
        o = obs1();
    endtask

    task automatic wr1(input int addr, input logic data);
        if1.iWR_VALID = 1; if1.iWR_ADDR = AW'(addr); if1.iWR_DATA = data;
        tick();
        if1.iWR_VALID = 0;
    endtask

    task automatic rd2(input int addr, output logic [31:0] o);
        if2.iVGA_VALID = 1; if2.iVGA_ADDR = AW'(addr);
        tick();
        if2.iVGA_VALID = 0;
        tick();
        o = obs2();
    endtask

    task automatic wr2(input int addr, input int data);
        if2.iWR_VALID = 1; if2.iWR_ADDR = AW'(addr); if2.iWR_DATA = 2'(data);
        tick();
        if2.iWR_VALID = 0;
        if (addr < DEPTH) mem_m[addr] = data;
    endtask

    task automatic pal2(input int idx, input logic [29:0] rgb);
        if2.iPAL_WE = 1; if2.iPAL_IDX = 2'(idx); if2.iPAL_RGB = rgb;
        tick();
        if2.iPAL_WE = 0;
        pal_m[idx] = rgb;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] o;
        logic [31:0] exp_now;
        int          n;
        bit          ready_ok;
        bit          pv;
        int          pidx;

        idle_inputs();
        reset_pal_model();

        // ---------------- reset state ----------------
        rst_n = 0;
        tick(); tick();
        check("rst_out1",   obs1(), 32'h0);
        check("rst_out2",   obs2(), 32'h0);
        check("rst_ready2", 32'(if2.oWR_READY), 32'd1);
        check("rst_busy2",  32'(if2.oFILL_BUSY), 32'd0);
        rst_n = 1;
        tick();

        // ---------------- BPP=1 legacy map ----------------
        wr1(5, 1'b1);
        wr1(6, 1'b0);
        rd1(5, o);
        check("bpp1_idx1", o, {2'b10, 30'h3FFF_FFFF});
        rd1(6, o);
        check("bpp1_idx0", o, {2'b10, 30'h0});

        // ---------------- fill engine ----------------
        pal2(3, {10'h123, 10'h045, 10'h2AB});
        if2.iFILL_START = 1; if2.iFILL_DATA = 2'd3;
        tick();
        if2.iFILL_START = 0;
        n = 0;
        ready_ok = 1;
        while (if2.oFILL_BUSY && n < 200) begin
            if (if2.oWR_READY !== 1'b0) ready_ok = 0;
            // A second start request and a host write are both ignored mid-fill.
            if2.iFILL_START = (n == 10);
            if2.iFILL_DATA  = 2'd1;
            if2.iWR_VALID   = (n == 20);
            if2.iWR_ADDR    = AW'(3);
            if2.iWR_DATA    = 2'd0;
            tick();
            n++;
        end
        if2.iFILL_START = 0;
        if2.iWR_VALID   = 0;
        check("fill_busy_cycles", 32'(n), 32'd64);
        check("fill_ready_low",   32'(ready_ok), 32'd1);
        check("fill_ready_after", 32'(if2.oWR_READY), 32'd1);
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 3;
        for (int a = 0; a < DEPTH; a++) begin
            rd2(a, o);
            check("fill_read", o, exp_read(a, 0));
        end

        // ---------------- palette entry 2, palette write in lookup cycle ----------------
        pal2(2, {10'h100, 10'h080, 10'h040});
        wr2(10, 2);
        rd2(10, o);
        check("pal2_read", o, {2'b10, 10'h100, 10'h080, 10'h040});
        if2.iVGA_VALID = 1; if2.iVGA_ADDR = AW'(10);
        tick();
        exp_now = exp_read(10, 0);
        if2.iPAL_WE = 1; if2.iPAL_IDX = 2'd2; if2.iPAL_RGB = {10'h001, 10'h002, 10'h003};
        tick();
        pal_m[2] = {10'h001, 10'h002, 10'h003};
        if2.iPAL_WE = 0; if2.iVGA_VALID = 0;
        check("pal_same_cycle_old", obs2(), exp_now);
        tick();
        check("pal_next_read_new", obs2(), exp_read(10, 0));

        // ---------------- write and read same address in one cycle ----------------
        wr2(7, 0);
        if2.iWR_VALID = 1; if2.iWR_ADDR = AW'(7); if2.iWR_DATA = 2'd1;
        if2.iVGA_VALID = 1; if2.iVGA_ADDR = AW'(7);
        exp_now = exp_read(7, 0);
        tick();
        mem_m[7] = 1;
        if2.iWR_VALID = 0;
        tick();
        if2.iVGA_VALID = 0;
        check("rdw_old", obs2(), exp_now);
        tick();
        check("rdw_new", obs2(), exp_read(7, 0));

        // ---------------- colour key and out-of-range addresses ----------------
        pal2(0, {10'h011, 10'h022, 10'h033});
        if2.iTRANSP_EN = 1;
        wr2(8, 0);
        rd2(8, o);
        check("transp_idx0", o, exp_read(8, 1));
        rd2(9, o);
        check("transp_idx3", o, exp_read(9, 1));
        rd2(DEPTH, o);
        check("oob_read", o, exp_read(DEPTH, 1));
        if2.iWR_VALID = 1; if2.iWR_ADDR = AW'(DEPTH); if2.iWR_DATA = 2'd2;
        check("oob_wr_ack", 32'(if2.oWR_READY), 32'd1);
        tick();
        if2.iWR_VALID = 0;
        rd2(0, o);
        check("oob_wr_noeffect0", o, exp_read(0, 1));
        rd2(DEPTH, o);
        check("oob_wr_noeffect", o, exp_read(DEPTH, 1));
        if2.iTRANSP_EN = 0;

        // ---------------- randomized traffic ----------------
        pv = 0;
        pidx = 0;
        for (int c = 0; c < 300; c++) begin
            bit          v, wv, pw, te;
            int          a, wa, wd, pi, cur;
            logic [29:0] prgb;
            v    = ($urandom % 4) != 0;
            a    = $urandom_range(0, DEPTH + 3);
            wv   = ($urandom % 3) == 0;
            wa   = $urandom_range(0, DEPTH + 2);
            wd   = $urandom % 4;
            pw   = ($urandom % 8) == 0;
            pi   = $urandom % 4;
            prgb = 30'($urandom);
            te   = $urandom % 2;
            // Lookup of last cycle's read sees the palette before this cycle's write.
            exp_now = pv ? {1'b1, te && (pidx == 0), pal_m[pidx]} : 32'h0;
            cur = (a < DEPTH) ? mem_m[a] : 0;
            if (wv && wa < DEPTH) mem_m[wa] = wd;
            if (pw) pal_m[pi] = prgb;
            if2.iVGA_VALID = v;  if2.iVGA_ADDR = AW'(a);
            if2.iWR_VALID = wv;  if2.iWR_ADDR = AW'(wa); if2.iWR_DATA = 2'(wd);
            if2.iPAL_WE = pw;    if2.iPAL_IDX = 2'(pi);  if2.iPAL_RGB = prgb;
            if2.iTRANSP_EN = te;
            tick();
            if (c > 0) check("rand", obs2(), exp_now);
            pv   = v;
            pidx = cur;
        end
        idle_inputs();
        tick();

        // ---------------- reset during fill ----------------
        if2.iFILL_START = 1; if2.iFILL_DATA = 2'd2;
        tick();
        if2.iFILL_START = 0;
        repeat (20) tick();
        rst_n = 0;
        #1;
        check("rstfill_busy",  32'(if2.oFILL_BUSY), 32'd0);
        check("rstfill_ready", 32'(if2.oWR_READY), 32'd1);
        for (int i = 0; i < 20; i++) mem_m[i] = 2;
        reset_pal_model();
        tick(); tick();
        rst_n = 1;
        tick();
        pal2(0, {10'h001, 10'h001, 10'h001});
        pal2(1, {10'h002, 10'h002, 10'h002});
        pal2(2, {10'h3C0, 10'h0F0, 10'h00F});
        pal2(3, {10'h004, 10'h004, 10'h004});
        for (int a = 0; a < 24; a++) begin
            rd2(a, o);
            check("rstfill_pix", o, exp_read(a, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
